// File: rtl/pinwheel_serial.sv
// ============================================================================
// Module  : pinwheel_serial
// Purpose : Memory-mapped serial peripheral with RX/TX byte FIFOs on the core bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pinwheel_serial #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_in,
    input  logic        bus_cs,
    input  logic [31:0] bus_addr,
    input  logic        bus_rden,
    input  logic        bus_wren,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wmask,
    output logic [31:0] bus_rdata,
    input  logic        serial_in_valid,
    input  logic [7:0]  serial_in_data,
    output logic        serial_out_valid,
    output logic [7:0]  serial_out_data,
    input  logic        serial_out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [1:0] C_REG_DATA   = 2'd0;
    localparam logic [1:0] C_REG_STATUS = 2'd1;

    logic [7:0]    r_rx_mem [DEPTH];
    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
    logic [CW-1:0] r_rx_count, r_tx_count;
    logic          r_rx_ovf, r_tx_ovf;
    logic [31:0]   r_rdata;

    logic          w_rd, w_wr, w_sel_data, w_sel_status;
    logic          w_rx_nonempty, w_rx_full, w_tx_nonempty, w_tx_full;
    logic          w_rx_push, w_rx_pop, w_rx_ovf_set;
    logic          w_tx_req, w_tx_push, w_tx_pop, w_tx_ovf_set;
    logic          w_w1c, w_clr_rx, w_clr_tx;
    logic [31:0]   w_status, w_rd_mux;
    logic          w_unused_bits;

    assign w_rd         = bus_cs & bus_rden;
    assign w_wr         = bus_cs & bus_wren;
    assign w_sel_data   = (bus_addr[3:2] == C_REG_DATA);
    assign w_sel_status = (bus_addr[3:2] == C_REG_STATUS);

    // Full/empty come from the pre-edge counts, so a same-cycle pop never rescues a push.
    assign w_rx_nonempty = (r_rx_count != '0);
    assign w_rx_full     = (r_rx_count == C_FULL);
    assign w_tx_nonempty = (r_tx_count != '0);
    assign w_tx_full     = (r_tx_count == C_FULL);

    assign w_rx_push    = serial_in_valid & ~w_rx_full;
    assign w_rx_ovf_set = serial_in_valid &  w_rx_full;
    assign w_rx_pop     = w_rd & w_sel_data & w_rx_nonempty;

    assign w_tx_req     = w_wr & w_sel_data & bus_wmask[0];
    assign w_tx_push    = w_tx_req & ~w_tx_full;
    assign w_tx_ovf_set = w_tx_req &  w_tx_full;
    assign w_tx_pop     = w_tx_nonempty & serial_out_ready;

    assign w_w1c    = w_wr & w_sel_status & bus_wmask[0];
    assign w_clr_rx = w_w1c & bus_wdata[2];
    assign w_clr_tx = w_w1c & bus_wdata[3];

    always_comb begin
        w_status            = '0;
        w_status[0]         = w_rx_nonempty;
        w_status[1]         = w_tx_full;
        w_status[2]         = r_rx_ovf;
        w_status[3]         = r_tx_ovf;
        w_status[8 +: CW]   = r_rx_count;
        w_status[16 +: CW]  = w_status[16 +: CW] | r_tx_count;
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus_addr[3:2])
            C_REG_DATA:   w_rd_mux = w_rx_nonempty ? {1'b1, 23'b0, r_rx_mem[r_rx_rptr]} : 32'h0;
            C_REG_STATUS: w_rd_mux = w_status;
            default:      w_rd_mux = '0;
        endcase
    end

    // FIFO storage carries no reset; pointers and counts define validity.
    always_ff @(posedge clock) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= serial_in_data;
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus_wdata[7:0];
    end

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_ovf   <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);

            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + CW'(1);
                2'b01:   r_rx_count <= r_rx_count - CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + CW'(1);
                2'b01:   r_tx_count <= r_tx_count - CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase

            r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~w_clr_rx);
            r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~w_clr_tx);

            if (w_rd) r_rdata <= w_rd_mux;
        end
    end

    assign bus_rdata        = r_rdata;
    assign serial_out_valid = w_tx_nonempty;
    assign serial_out_data  = w_tx_nonempty ? r_tx_mem[r_tx_rptr] : 8'h00;

    assign w_unused_bits = &{1'b0, bus_addr[31:4], bus_addr[1:0], bus_wdata[31:8], bus_wmask[3:1]};

endmodule

`default_nettype wire

// File: tb/tb_pinwheel_serial.sv
// ============================================================================
// Module  : tb_pinwheel_serial
// Purpose : Scoreboard bench for pinwheel_serial (bus reads and TX stream).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pinwheel_serial;

    logic        clock = 1'b0;
    logic        reset_in = 1'b1;
    logic        bus_cs = 1'b0;
    logic [31:0] bus_addr = '0;
    logic        bus_rden = 1'b0;
    logic        bus_wren = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [3:0]  bus_wmask = '0;
    logic [31:0] bus_rdata;
    logic        serial_in_valid = 1'b0;
    logic [7:0]  serial_in_data = '0;
    logic        serial_out_valid;
    logic [7:0]  serial_out_data;
    logic        serial_out_ready = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    bit          rd_pend = 1'b0;

    pinwheel_serial #(.DEPTH(16)) dut (
        .clock            (clock),
        .reset_in         (reset_in),
        .bus_cs           (bus_cs),
        .bus_addr         (bus_addr),
        .bus_rden         (bus_rden),
        .bus_wren         (bus_wren),
        .bus_wdata        (bus_wdata),
        .bus_wmask        (bus_wmask),
        .bus_rdata        (bus_rdata),
        .serial_in_valid  (serial_in_valid),
        .serial_in_data   (serial_in_data),
        .serial_out_valid (serial_out_valid),
        .serial_out_data  (serial_out_data),
        .serial_out_ready (serial_out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Monitor: inputs change just after posedge, so the negedge sees stable values.
    always @(negedge clock) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) chk("rdata_unexpected", bus_rdata, 32'hDEADBEEF);
            else chk("rdata", bus_rdata, exp_rd.pop_front());
        end
        rd_pend = !reset_in && bus_cs && bus_rden;
        if (!reset_in && serial_out_valid && serial_out_ready) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, serial_out_data}, 32'hDEADBEEF);
            else chk("txdata", {24'h0, serial_out_data}, {24'h0, exp_tx.pop_front()});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        bus_cs = 1'b0; bus_rden = 1'b0; bus_wren = 1'b0;
        bus_addr = '0; bus_wdata = '0; bus_wmask = '0;
        serial_in_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
        exp_rd.push_back(exp);
        bus_cs = 1'b1; bus_rden = 1'b1; bus_addr = 32'hC000_0000 | addr;
        step();
        idle_bus();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input bit expect_tx);
        if (expect_tx) exp_tx.push_back(data[7:0]);
        bus_cs = 1'b1; bus_wren = 1'b1; bus_addr = 32'hC000_0000 | addr;
        bus_wdata = data; bus_wmask = mask;
        step();
        idle_bus();
    endtask

    task automatic inject(input logic [7:0] b);
        serial_in_valid = 1'b1; serial_in_data = b;
        step();
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        step();
        chk("rst_rdata", bus_rdata, 32'h0);
        chk("rst_valid", {31'h0, serial_out_valid}, 32'h0);
        chk("rst_data", {24'h0, serial_out_data}, 32'h0);
        step(); step();
        reset_in = 1'b0;
        step();
        bus_read(32'h4, 32'h0000_0000);
        bus_read(32'h0, 32'h0000_0000);
        bus_read(32'h8, 32'h0000_0000);

        // RX path
        inject(8'h41);
        inject(8'h42);
        bus_read(32'h4, 32'h0000_0201);
        bus_read(32'h0, 32'h8000_0041);
        bus_read(32'h3, 32'h8000_0042);   // low address bits ignored
        bus_read(32'h0, 32'h0000_0000);

        // TX with backpressure
        bus_write(32'h0, 32'h0000_0055, 4'h1, 1'b1);
        bus_write(32'h0, 32'h1234_56AA, 4'h1, 1'b1);
        chk("tx_hold_valid", {31'h0, serial_out_valid}, 32'h1);
        chk("tx_hold_data", {24'h0, serial_out_data}, 32'h55);
        bus_read(32'h4, 32'h0002_0000);
        chk("tx_hold_data2", {24'h0, serial_out_data}, 32'h55);
        serial_out_ready = 1'b1;
        step();
        chk("tx_next_data", {24'h0, serial_out_data}, 32'hAA);
        step();
        chk("tx_drained", {31'h0, serial_out_valid}, 32'h0);
        serial_out_ready = 1'b0;

        // RX overflow and pointer wrap, three passes
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 17; i++) inject(8'(i));
            bus_read(32'h4, 32'h0000_1005);
            for (int i = 0; i < 16; i++) bus_read(32'h0, 32'h8000_0000 | i);
            bus_read(32'h4, 32'h0000_0004);
            bus_write(32'h4, 32'h0000_0004, 4'h1, 1'b0);
            bus_read(32'h4, 32'h0000_0000);
        end

        // Full RX + push + DATA read in one cycle
        for (int i = 0; i < 16; i++) inject(8'h20 + 8'(i));
        exp_rd.push_back(32'h8000_0020);
        serial_in_valid = 1'b1; serial_in_data = 8'hEE;
        bus_cs = 1'b1; bus_rden = 1'b1; bus_addr = 32'hC000_0000;
        step();
        idle_bus();
        bus_read(32'h4, 32'h0000_0F05);
        for (int i = 1; i < 16; i++) bus_read(32'h0, 32'h8000_0020 + i);
        bus_read(32'h0, 32'h0000_0000);
        bus_write(32'h4, 32'h0000_0004, 4'h1, 1'b0);

        // Masked-off write ignored; deselected write ignored
        bus_write(32'h0, 32'h0000_0099, 4'hE, 1'b0);
        bus_wren = 1'b1; bus_wdata = 32'h0000_0033; bus_wmask = 4'hF;
        step();
        idle_bus();
        bus_read(32'h4, 32'h0000_0000);

        // TX overflow then drain at one byte per cycle
        for (int i = 0; i < 16; i++) bus_write(32'h0, 32'h60 + i, 4'h1, 1'b1);
        bus_write(32'h0, 32'h0000_00FF, 4'h1, 1'b0);
        bus_read(32'h4, 32'h0010_000A);
        serial_out_ready = 1'b1;
        repeat (16) step();
        chk("tx_ovf_drained", {31'h0, serial_out_valid}, 32'h0);
        bus_write(32'h4, 32'h0000_0008, 4'h1, 1'b0);
        bus_read(32'h4, 32'h0000_0000);

        // Empty TX + write with ready high: visible next cycle
        chk("tx_empty_before", {31'h0, serial_out_valid}, 32'h0);
        bus_write(32'h0, 32'h0000_0077, 4'h1, 1'b1);
        chk("tx_new_valid", {31'h0, serial_out_valid}, 32'h1);
        chk("tx_new_data", {24'h0, serial_out_data}, 32'h77);
        step();
        chk("tx_new_gone", {31'h0, serial_out_valid}, 32'h0);
        serial_out_ready = 1'b0;

        // Async reset mid-drain
        for (int i = 0; i < 5; i++) bus_write(32'h0, 32'hA0 + i, 4'h1, 1'b0);
        bus_read(32'h4, 32'h0005_0000);
        @(posedge clock);
        #2;
        reset_in = 1'b1;
        #1;
        chk("async_valid", {31'h0, serial_out_valid}, 32'h0);
        chk("async_data", {24'h0, serial_out_data}, 32'h0);
        chk("async_rdata", bus_rdata, 32'h0);
        step();
        reset_in = 1'b0;
        step();
        bus_read(32'h4, 32'h0000_0000);

        repeat (3) step();
        chk("rd_queue_empty", exp_rd.size(), 32'h0);
        chk("tx_queue_empty", exp_tx.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
